// File: rtl/inst_fetch_if.sv
// Instruction-memory read bus between the fetch stage and the instruction ROM.
// Latency: wires only, no storage in the bundle.
// Backpressure: master holds rom_req/rom_addr until the edge that samples rom_ack=1.
//
// Signals: rom_req   - read request (master -> slave)
//          rom_addr  - read address (master -> slave)
//          rom_ack   - read complete, may coincide with rom_req rising (slave -> master)
//          rom_rdata - read data, valid with rom_ack (slave -> master)
interface inst_fetch_if;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_rdata;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_ack,
        input  rom_rdata
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_ack,
        output rom_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: pc-driven ROM reads into a registered inst/inst_addr pair.
// Latency: one edge from rom_ack=1 to inst/inst_addr; zero-wait ROM gives one instruction per cycle.
// Backpressure: hold_en freezes outputs; one fetched word is parked in a 1-entry buffer and rom_req drops.
//
// Ports: sys_clk, sys_rst_n (async, active-low)
//        jump_en/jump_addr - redirect from execute; beats hold_en and rom_ack
//        hold_en           - downstream stall
//        rom               - inst_fetch_if master (rom_req/rom_addr out, rom_ack/rom_rdata in)
//        inst/inst_addr    - registered instruction and its address to decode
//        misalign_err      - one-cycle pulse on a misaligned jump target
// Optional feature macro: FETCH_MISALIGN_CHK_EN (check and align jump targets; default off).
module inst_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         jump_en,
    input  logic [31:0]  jump_addr,
    input  logic         hold_en,
    inst_fetch_if.master rom,
    output logic [31:0]  inst,
    output logic [31:0]  inst_addr,
    output logic         misalign_err
);
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        buf_vld_q, buf_vld_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] buf_addr_q, buf_addr_d;
    logic [31:0] tgt_q, tgt_d;     // redirect target parked while FLUSH drains the old read
    logic [31:0] jump_tgt;
    logic        ack_hit;
    logic        pending;

    // An ack only counts against a live request; acks seen with rom_req=0 are stale.
    assign ack_hit = req_q & rom.rom_ack;
    assign pending = req_q & ~rom.rom_ack;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    assign jump_tgt = {jump_addr[31:2], 2'b00};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= jump_en & (jump_addr[1:0] != 2'b00);
        end
    end

    assign misalign_err = misalign_q;
`else
    assign jump_tgt     = jump_addr;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        buf_vld_d   = buf_vld_q;
        buf_inst_d  = buf_inst_q;
        buf_addr_d  = buf_addr_q;
        tgt_d       = tgt_q;

        case (state_q)
            FETCH: begin
                req_d = 1'b1;
                if (jump_en) begin
                    inst_d    = INST_NOP;
                    buf_vld_d = 1'b0;
                    if (pending) begin
                        // Old read still in flight: keep its address on the bus until it acks.
                        state_d = FLUSH;
                        tgt_d   = jump_tgt;
                    end else begin
                        // Nothing outstanding (or it acks now and is dropped): redirect at once.
                        pc_d = jump_tgt;
                    end
                end else if (hold_en) begin
                    if (ack_hit) begin
                        buf_vld_d  = 1'b1;
                        buf_inst_d = rom.rom_rdata;
                        buf_addr_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                        req_d      = 1'b0;
                        state_d    = HOLD;
                    end
                end else if (ack_hit) begin
                    inst_d      = rom.rom_rdata;
                    inst_addr_d = pc_q;
                    pc_d        = pc_q + 32'd4;
                end else begin
                    inst_d = INST_NOP;
                end
            end

            HOLD: begin
                if (jump_en) begin
                    pc_d      = jump_tgt;
                    inst_d    = INST_NOP;
                    buf_vld_d = 1'b0;
                    req_d     = 1'b1;
                    state_d   = FETCH;
                end else if (!hold_en) begin
                    inst_d      = buf_vld_q ? buf_inst_q : INST_NOP;
                    inst_addr_d = buf_addr_q;
                    buf_vld_d   = 1'b0;
                    req_d       = 1'b1;
                    state_d     = FETCH;
                end
            end

            FLUSH: begin
                // A newer redirect replaces the parked one; the in-flight data is discarded.
                if (jump_en) begin
                    tgt_d = jump_tgt;
                end
                if (ack_hit) begin
                    pc_d    = jump_en ? jump_tgt : tgt_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_ADDR;
            req_q       <= 1'b0;
            inst_q      <= INST_NOP;
            inst_addr_q <= 32'h0;
            buf_vld_q   <= 1'b0;
            buf_inst_q  <= 32'h0;
            buf_addr_q  <= 32'h0;
            tgt_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            buf_vld_q   <= buf_vld_d;
            buf_inst_q  <= buf_inst_d;
            buf_addr_q  <= buf_addr_d;
            tgt_q       <= tgt_d;
        end
    end

    assign rom.rom_req  = req_q;
    assign rom.rom_addr = pc_q;
    assign inst         = inst_q;
    assign inst_addr    = inst_addr_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, ROM latency, hold, flush, wrap, misalign.
// Latency: n/a (bench).
// Backpressure: n/a (bench drives hold_en and rom_ack directly).
module tb_inst_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_en;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch_if bus ();

    inst_fetch #(.RESET_ADDR(32'h0000_0000)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .jump_en      (jump_en),
        .jump_addr    (jump_addr),
        .hold_en      (hold_en),
        .rom          (bus),
        .inst         (inst),
        .inst_addr    (inst_addr),
        .misalign_err (misalign_err)
    );

    // ROM contents: each word is its own address xor KEY.
    always_comb bus.rom_rdata = bus.rom_addr ^ KEY;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n   = 1'b0;
        jump_en     = 1'b0;
        hold_en     = 1'b0;
        bus.rom_ack = 1'b0;
        step();
        step();
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rom_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0h exp 0", bus.rom_req); end
        n_checks++; if (bus.rom_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %0h exp 0", bus.rom_addr); end
        n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL reset_inst got %0h exp %0h", inst, NOP); end
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL reset_inst_addr got %0h exp 0", inst_addr); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %0h exp 0", misalign_err); end
        bus.rom_ack = 1'b1;
        step();
        step();
        n_checks++; if (bus.rom_req !== 1'b0) begin n_fail++; $display("FAIL reset_hold_req got %0h exp 0", bus.rom_req); end
        sys_rst_n = 1'b1;
        step();
        n_checks++; if (bus.rom_req !== 1'b1) begin n_fail++; $display("FAIL first_req got %0h exp 1", bus.rom_req); end
        n_checks++; if (bus.rom_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr got %0h exp 0", bus.rom_addr); end
        n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL first_inst got %0h exp %0h", inst, NOP); end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        for (int k = 0; k < 4; k++) begin
            a = 32'(4 * k);
            step();
            n_checks++; if (inst_addr !== a) begin n_fail++; $display("FAIL stream_addr[%0d] got %0h exp %0h", k, inst_addr, a); end
            n_checks++; if (inst !== (a ^ KEY)) begin n_fail++; $display("FAIL stream_inst[%0d] got %0h exp %0h", k, inst, a ^ KEY); end
        end
    endtask

    task automatic test_latency();
        logic [31:0] a;
        for (int k = 0; k < 3; k++) begin
            a = 32'h10 + 32'(4 * k);
            bus.rom_ack = 1'b0;
            step();
            n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL lat_nop[%0d] got %0h exp %0h", k, inst, NOP); end
            n_checks++; if (bus.rom_addr !== a) begin n_fail++; $display("FAIL lat_addr[%0d] got %0h exp %0h", k, bus.rom_addr, a); end
            n_checks++; if (bus.rom_req !== 1'b1) begin n_fail++; $display("FAIL lat_req[%0d] got %0h exp 1", k, bus.rom_req); end
            bus.rom_ack = 1'b1;
            step();
            n_checks++; if (inst_addr !== a) begin n_fail++; $display("FAIL lat_inst_addr[%0d] got %0h exp %0h", k, inst_addr, a); end
            n_checks++; if (inst !== (a ^ KEY)) begin n_fail++; $display("FAIL lat_inst[%0d] got %0h exp %0h", k, inst, a ^ KEY); end
        end
    endtask

    task automatic test_hold();
        do_reset();
        bus.rom_ack = 1'b1;
        for (int k = 0; k < 5; k++) step();   // fetches 0x0..0xC, pc now 0x10
        hold_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (bus.rom_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d] got %0h exp 0", k, bus.rom_req); end
            n_checks++; if (inst_addr !== 32'hC) begin n_fail++; $display("FAIL hold_inst_addr[%0d] got %0h exp c", k, inst_addr); end
            n_checks++; if (inst !== (32'hC ^ KEY)) begin n_fail++; $display("FAIL hold_inst[%0d] got %0h exp %0h", k, inst, 32'hC ^ KEY); end
        end
        hold_en = 1'b0;
        step();
        n_checks++; if (inst_addr !== 32'h10) begin n_fail++; $display("FAIL release_inst_addr got %0h exp 10", inst_addr); end
        n_checks++; if (inst !== (32'h10 ^ KEY)) begin n_fail++; $display("FAIL release_inst got %0h exp %0h", inst, 32'h10 ^ KEY); end
        n_checks++; if (bus.rom_req !== 1'b1) begin n_fail++; $display("FAIL release_req got %0h exp 1", bus.rom_req); end
        n_checks++; if (bus.rom_addr !== 32'h14) begin n_fail++; $display("FAIL release_addr got %0h exp 14", bus.rom_addr); end
        step();
        n_checks++; if (inst_addr !== 32'h14) begin n_fail++; $display("FAIL after_hold_addr got %0h exp 14", inst_addr); end
    endtask

    task automatic test_flush();
        step();
        step();
        n_checks++; if (bus.rom_addr !== 32'h20) begin n_fail++; $display("FAIL pre_flush_addr got %0h exp 20", bus.rom_addr); end
        bus.rom_ack = 1'b0;
        step();
        jump_en   = 1'b1;
        jump_addr = 32'h100;
        step();
        jump_en = 1'b0;
        n_checks++; if (bus.rom_addr !== 32'h20) begin n_fail++; $display("FAIL flush_addr got %0h exp 20", bus.rom_addr); end
        n_checks++; if (bus.rom_req !== 1'b1) begin n_fail++; $display("FAIL flush_req got %0h exp 1", bus.rom_req); end
        n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL flush_inst got %0h exp %0h", inst, NOP); end
        step();
        n_checks++; if (bus.rom_addr !== 32'h20) begin n_fail++; $display("FAIL flush_wait_addr got %0h exp 20", bus.rom_addr); end
        bus.rom_ack = 1'b1;
        step();
        n_checks++; if (bus.rom_addr !== 32'h100) begin n_fail++; $display("FAIL flush_target got %0h exp 100", bus.rom_addr); end
        n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL flush_discard got %0h exp %0h", inst, NOP); end
        n_checks++; if (inst_addr !== 32'h1C) begin n_fail++; $display("FAIL flush_keep_addr got %0h exp 1c", inst_addr); end
        step();
        n_checks++; if (inst_addr !== 32'h100) begin n_fail++; $display("FAIL jump_inst_addr got %0h exp 100", inst_addr); end
        n_checks++; if (inst !== (32'h100 ^ KEY)) begin n_fail++; $display("FAIL jump_inst got %0h exp %0h", inst, 32'h100 ^ KEY); end
        // second redirect while flushing replaces the first
        bus.rom_ack = 1'b0;
        step();
        jump_en   = 1'b1;
        jump_addr = 32'h300;
        step();
        jump_addr = 32'h400;
        step();
        n_checks++; if (bus.rom_addr !== 32'h104) begin n_fail++; $display("FAIL reflush_addr got %0h exp 104", bus.rom_addr); end
        jump_en     = 1'b0;
        bus.rom_ack = 1'b1;
        step();
        n_checks++; if (bus.rom_addr !== 32'h400) begin n_fail++; $display("FAIL reflush_target got %0h exp 400", bus.rom_addr); end
        step();
        n_checks++; if (inst_addr !== 32'h400) begin n_fail++; $display("FAIL reflush_inst_addr got %0h exp 400", inst_addr); end
    endtask

    task automatic test_wrap();
        bus.rom_ack = 1'b1;
        jump_en     = 1'b1;
        jump_addr   = 32'hFFFF_FFFC;
        step();
        jump_en = 1'b0;
        n_checks++; if (bus.rom_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_start got %0h exp fffffffc", bus.rom_addr); end
        n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL wrap_jump_nop got %0h exp %0h", inst, NOP); end
        step();
        n_checks++; if (inst_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_inst_addr got %0h exp fffffffc", inst_addr); end
        n_checks++; if (bus.rom_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got %0h exp 0", bus.rom_addr); end
        step();
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next got %0h exp 0", inst_addr); end
    endtask

    task automatic test_misalign();
        logic        exp_err;
        logic [31:0] exp_addr;
`ifdef FETCH_MISALIGN_CHK_EN
        exp_err  = 1'b1;
        exp_addr = 32'h100;
`else
        exp_err  = 1'b0;
        exp_addr = 32'h102;
`endif
        bus.rom_ack = 1'b1;
        jump_en     = 1'b1;
        jump_addr   = 32'h102;
        step();
        jump_en = 1'b0;
        n_checks++; if (misalign_err !== exp_err) begin n_fail++; $display("FAIL misalign_pulse got %0h exp %0h", misalign_err, exp_err); end
        n_checks++; if (bus.rom_addr !== exp_addr) begin n_fail++; $display("FAIL misalign_addr got %0h exp %0h", bus.rom_addr, exp_addr); end
        step();
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_end got %0h exp 0", misalign_err); end
    endtask

    task automatic test_reset_mid();
        bus.rom_ack = 1'b0;
        step();
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rom_req !== 1'b0) begin n_fail++; $display("FAIL mid_reset_req got %0h exp 0", bus.rom_req); end
        n_checks++; if (bus.rom_addr !== 32'h0) begin n_fail++; $display("FAIL mid_reset_addr got %0h exp 0", bus.rom_addr); end
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL mid_reset_inst_addr got %0h exp 0", inst_addr); end
        bus.rom_ack = 1'b1;
        step();
        step();
        sys_rst_n = 1'b1;
        step();
        n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL stale_ack_inst got %0h exp %0h", inst, NOP); end
        n_checks++; if (bus.rom_req !== 1'b1) begin n_fail++; $display("FAIL mid_restart_req got %0h exp 1", bus.rom_req); end
        step();
        n_checks++; if (inst !== KEY) begin n_fail++; $display("FAIL mid_restart_inst got %0h exp %0h", inst, KEY); end
    endtask

    initial begin
        sys_rst_n   = 1'b1;
        jump_en     = 1'b0;
        jump_addr   = 32'h0;
        hold_en     = 1'b0;
        bus.rom_ack = 1'b0;
        #2;
        test_reset();
        test_stream();
        test_latency();
        test_hold();
        test_flush();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
